// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin transmit arbiter and config sequencer toward uart_top 4-phase handshakes
// Optional ack timeout and sticky timeout_err port enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int UART_DATA_WIDTH = 8,
    parameter int CONFIG_WIDTH    = 8,
    parameter int SYNC_STAGE      = 2,
    parameter int TIMEOUT         = 1024,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               cfg_valid,
    input  logic [CONFIG_WIDTH-1:0]            cfg_data,
    output logic                               cfg_ready,
    output logic                               async_tx_d_req,
    input  logic                               async_tx_d_ack,
    output logic [UART_DATA_WIDTH-1:0]         async_tx_d,
    output logic                               async_conf_req,
    input  logic                               async_conf_ack,
    output logic [CONFIG_WIDTH-1:0]            async_conf,
    output logic [IDW-1:0]                     grant_id,
`ifdef UART_TX_SCHED_TIMEOUT_EN
    output logic                               timeout_err,
`endif
    output logic                               busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        D_REQ = 3'd1,
        D_REL = 3'd2,
        C_REQ = 3'd3,
        C_REL = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [SYNC_STAGE-1:0]        r_dack_sync;
    logic [SYNC_STAGE-1:0]        r_cack_sync;
    logic                         w_dack_s;
    logic                         w_cack_s;
    logic                         r_run;
    logic [IDW-1:0]               r_ptr;
    logic [IDW-1:0]               w_ptr_nxt;
    logic [IDW-1:0]               w_pick;
    logic [IDW:0]                 w_idx;
    logic                         w_found;
    logic                         w_grant_d;
    logic                         w_grant_c;
    logic                         r_dreq;
    logic                         r_creq;
    logic [UART_DATA_WIDTH-1:0]   r_tx_d;
    logic [CONFIG_WIDTH-1:0]      r_conf;
    logic [IDW-1:0]               r_gid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dack_sync <= '0;
            r_cack_sync <= '0;
        end else begin
            r_dack_sync <= {r_dack_sync[SYNC_STAGE-2:0], async_tx_d_ack};
            r_cack_sync <= {r_cack_sync[SYNC_STAGE-2:0], async_conf_ack};
        end
    end

    assign w_dack_s = r_dack_sync[SYNC_STAGE-1];
    assign w_cack_s = r_cack_sync[SYNC_STAGE-1];

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IDW-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_pick == IDW'(NUM_REQ-1)) ? '0 : w_pick + IDW'(1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] r_cnt;
    logic          r_tmo_err;
    logic          w_tmo;
`endif

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_c = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        w_tmo     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // r_run keeps ready pulses off during reset; acks must both be low before any grant.
                if (r_run && !w_dack_s && !w_cack_s) begin
                    if (cfg_valid) begin
                        w_grant_c = 1'b1;
                        w_next    = C_REQ;
                    end else if (w_found) begin
                        w_grant_d = 1'b1;
                        w_next    = D_REQ;
                    end
                end
            end
            D_REQ:   if (w_dack_s)  w_next = D_REL;
            D_REL:   if (!w_dack_s) w_next = IDLE;
            C_REQ:   if (w_cack_s)  w_next = C_REL;
            C_REL:   if (!w_cack_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
`ifdef UART_TX_SCHED_TIMEOUT_EN
        if (r_state != IDLE && r_cnt == CW'(TIMEOUT-1)) begin
            w_next = IDLE;
            w_tmo  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_ptr   <= '0;
            r_dreq  <= 1'b0;
            r_creq  <= 1'b0;
            r_tx_d  <= '0;
            r_conf  <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_dreq  <= (w_next == D_REQ);
            r_creq  <= (w_next == C_REQ);
            if (w_grant_d) begin
                r_tx_d <= req_data[w_pick*UART_DATA_WIDTH +: UART_DATA_WIDTH];
                r_gid  <= w_pick;
                r_ptr  <= w_ptr_nxt;
            end
            if (w_grant_c) begin
                r_conf <= cfg_data;
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Counter restarts on every state change so each wait phase gets its own budget.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_next != r_state || r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_tmo_err;
`endif

    assign req_ready      = w_grant_d ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick) : '0;
    assign cfg_ready      = w_grant_c;
    assign async_tx_d_req = r_dreq;
    assign async_conf_req = r_creq;
    assign async_tx_d     = r_tx_d;
    assign async_conf     = r_conf;
    assign grant_id       = r_gid;
    assign busy           = (r_state != IDLE);

endmodule
